// File: rtl/srambank_arb2_ctrl_if.sv
// Requester-side request/response bundle for one port of srambank_arb2_ctrl.
// master = requester, slave = controller; ready is combinational, rsp_valid is a one-cycle pulse.
interface srambank_arb2_ctrl_if #(
    parameter int AW = 9,
    parameter int DW = 48
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/srambank_arb2_ctrl.sv
// Two-port round-robin controller for one synchronous SRAM bank; optional zero-fill via SRAMBANK_ARB_INIT_CLEAR_EN.
// Latency: fire -> bank pins next cycle; read data on rsp 2 cycles after fire.
// Backpressure: at most one combinational ready per cycle, only once init_done is high.
module srambank_arb2_ctrl #(
    parameter int AW = 9,
    parameter int DW = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    srambank_arb2_ctrl_if.slave  req0_if,
    srambank_arb2_ctrl_if.slave  req1_if,
    output logic [AW-1:0]        ADDRESS_o,
    output logic [DW-1:0]        wd_o,
    output logic                 banksel_o,
    output logic                 read_o,
    output logic                 write_o,
    input  logic [DW-1:0]        dataout_i,
    output logic                 init_done_o
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef SRAMBANK_ARB_INIT_CLEAR_EN
    localparam state_t RST_STATE = ST_INIT;
    logic [AW-1:0] cnt_q;
`else
    localparam state_t RST_STATE = ST_RUN;
`endif

    state_t        state_q;
    logic          init_done_q;
    logic          prio_q;          // port that wins the next tie
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wd_q;
    logic          bsel_q, rd_q, wr_q;
    logic          s0_vld_q, s0_port_q, s1_vld_q, s1_port_q;

    logic          v0, v1, gnt0, gnt1, fire;
    logic          sel_write;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign v0   = req0_if.req_valid;
    assign v1   = req1_if.req_valid;
    assign gnt0 = init_done_q & v0 & (~v1 | ~prio_q);
    assign gnt1 = init_done_q & v1 & (~v0 | prio_q);
    assign fire = gnt0 | gnt1;

    assign sel_write = gnt1 ? req1_if.req_write : req0_if.req_write;
    assign sel_addr  = gnt1 ? req1_if.req_addr  : req0_if.req_addr;
    assign sel_wdata = gnt1 ? req1_if.req_wdata : req0_if.req_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            init_done_q <= 1'b0;
            prio_q      <= 1'b0;
            addr_q      <= '0;
            wd_q        <= '0;
            bsel_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            s0_vld_q    <= 1'b0;
            s0_port_q   <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_port_q   <= 1'b0;
`ifdef SRAMBANK_ARB_INIT_CLEAR_EN
            cnt_q       <= '0;
`endif
        end else begin
            bsel_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            s0_vld_q  <= 1'b0;
            s1_vld_q  <= s0_vld_q;
            s1_port_q <= s0_port_q;
            case (state_q)
`ifdef SRAMBANK_ARB_INIT_CLEAR_EN
                ST_INIT: begin
                    addr_q <= cnt_q;
                    wd_q   <= '0;
                    bsel_q <= 1'b1;
                    wr_q   <= 1'b1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == {AW{1'b1}}) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    init_done_q <= 1'b1;
                    if (fire) begin
                        // after a grant the other port gets the next tie
                        prio_q <= gnt0;
                        addr_q <= sel_addr;
                        bsel_q <= 1'b1;
                        if (sel_write) begin
                            wr_q <= 1'b1;
                            wd_q <= sel_wdata;
                        end else begin
                            rd_q      <= 1'b1;
                            s0_vld_q  <= 1'b1;
                            s0_port_q <= gnt1;
                        end
                    end
                end
            endcase
        end
    end

    assign req0_if.req_ready = gnt0;
    assign req1_if.req_ready = gnt1;
    // bank output register is read directly; the tracker only steers the valid
    assign req0_if.rsp_valid = s1_vld_q & ~s1_port_q;
    assign req1_if.rsp_valid = s1_vld_q &  s1_port_q;
    assign req0_if.rsp_data  = dataout_i;
    assign req1_if.rsp_data  = dataout_i;

    assign ADDRESS_o   = addr_q;
    assign wd_o        = wd_q;
    assign banksel_o   = bsel_q;
    assign read_o      = rd_q;
    assign write_o     = wr_q;
    assign init_done_o = init_done_q;
endmodule

// File: tb/tb_srambank_arb2_ctrl.sv
// Directed bench for srambank_arb2_ctrl with a behavioural 512x48 bank model.
module tb_srambank_arb2_ctrl;
    localparam int AW = 9;
    localparam int DW = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    srambank_arb2_ctrl_if #(.AW(AW), .DW(DW)) p0 ();
    srambank_arb2_ctrl_if #(.AW(AW), .DW(DW)) p1 ();

    logic [AW-1:0] address;
    logic [DW-1:0] wd, dataout;
    logic          banksel, rd, wr, init_done;

    srambank_arb2_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_if     (p0),
        .req1_if     (p1),
        .ADDRESS_o   (address),
        .wd_o        (wd),
        .banksel_o   (banksel),
        .read_o      (rd),
        .write_o     (wr),
        .dataout_i   (dataout),
        .init_done_o (init_done)
    );

    logic [DW-1:0] mem [512];
    always @(posedge clk) begin
        if (banksel && wr) mem[address] <= wd;
        if (banksel && rd) dataout <= mem[address];
    end

    int nvec = 0;
    int nerr = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin
            p0.req_valid = v; p0.req_write = w; p0.req_addr = a; p0.req_wdata = d;
        end else begin
            p1.req_valid = v; p1.req_write = w; p1.req_addr = a; p1.req_wdata = d;
        end
    endtask

    task automatic wait_init;
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        nvec++;
        if (init_done !== 1'b1) begin
            nerr++;
            $display("FAIL wait_init: init_done=%b after %0d cycles, required 1", init_done, n);
        end
    endtask

    task automatic test_reset;
        set_req(0, 1'b1, 1'b0, 9'h000, 48'h0);
        set_req(1, 1'b1, 1'b0, 9'h000, 48'h0);
        rst = 1'b1;
        repeat (3) tick();
        nvec++; if ({banksel, rd, wr} !== 3'b000) begin nerr++; $display("FAIL reset_strobes: bsel/rd/wr=%b required 000", {banksel, rd, wr}); end
        nvec++; if (address !== 9'h0 || wd !== 48'h0) begin nerr++; $display("FAIL reset_bus: addr=%h wd=%h required 0/0", address, wd); end
        nvec++; if (init_done !== 1'b0) begin nerr++; $display("FAIL reset_init_done: %b required 0", init_done); end
        nvec++; if ({p0.req_ready, p1.req_ready} !== 2'b00) begin nerr++; $display("FAIL reset_ready: %b required 00", {p0.req_ready, p1.req_ready}); end
        nvec++; if ({p0.rsp_valid, p1.rsp_valid} !== 2'b00) begin nerr++; $display("FAIL reset_rsp: %b required 00", {p0.rsp_valid, p1.rsp_valid}); end
        set_req(0, 1'b0, 1'b0, 9'h000, 48'h0);
        set_req(1, 1'b0, 1'b0, 9'h000, 48'h0);
        rst = 1'b0;
        nvec++; if (init_done !== 1'b0) begin nerr++; $display("FAIL release_init_done: %b required 0", init_done); end
        tick();
`ifdef SRAMBANK_ARB_INIT_CLEAR_EN
        for (int i = 0; i < 512; i++) begin
            nvec++;
            if (address !== i[AW-1:0] || wd !== 48'h0 || {banksel, rd, wr} !== 3'b101 ||
                init_done !== (i == 511)) begin
                nerr++;
                $display("FAIL init_fill[%0d]: addr=%h wd=%h bsel/rd/wr=%b init_done=%b required addr=%h wd=0 101 %b",
                         i, address, wd, {banksel, rd, wr}, init_done, i[AW-1:0], (i == 511));
            end
            tick();
        end
        nvec++; if (init_done !== 1'b1 || {banksel, rd, wr} !== 3'b000) begin nerr++; $display("FAIL init_end: init_done=%b bsel/rd/wr=%b required 1/000", init_done, {banksel, rd, wr}); end
        set_req(0, 1'b1, 1'b0, 9'h1A5, 48'h0);
        #1;
        nvec++; if (p0.req_ready !== 1'b1) begin nerr++; $display("FAIL init_read_ready: %b required 1", p0.req_ready); end
        tick();
        set_req(0, 1'b0, 1'b0, 9'h000, 48'h0);
        tick();
        nvec++; if (p0.rsp_valid !== 1'b1 || p0.rsp_data !== 48'h0) begin nerr++; $display("FAIL init_read_1a5: valid=%b data=%h required 1/0", p0.rsp_valid, p0.rsp_data); end
        tick();
`else
        nvec++; if (init_done !== 1'b1) begin nerr++; $display("FAIL run_after_reset: init_done=%b required 1", init_done); end
`endif
    endtask

    task automatic test_idle;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if ({banksel, rd, wr} !== 3'b000 || {p0.req_ready, p1.req_ready} !== 2'b00) begin
                nerr++;
                $display("FAIL idle[%0d]: bsel/rd/wr=%b ready=%b required 000/00", i, {banksel, rd, wr}, {p0.req_ready, p1.req_ready});
            end
            tick();
        end
    endtask

    task automatic test_single_port;
        logic [DW-1:0] d;
        d = 48'h123456789ABC;
        set_req(0, 1'b1, 1'b1, 9'h007, d);
        #1;
        nvec++; if ({p0.req_ready, p1.req_ready} !== 2'b10) begin nerr++; $display("FAIL sp_wr_ready: %b required 10", {p0.req_ready, p1.req_ready}); end
        tick();
        nvec++; if ({banksel, rd, wr} !== 3'b101 || address !== 9'h007 || wd !== d) begin nerr++; $display("FAIL sp_wr_pins: bsel/rd/wr=%b addr=%h wd=%h required 101/007/%h", {banksel, rd, wr}, address, wd, d); end
        set_req(0, 1'b1, 1'b0, 9'h007, 48'h0);
        #1;
        nvec++; if (p0.req_ready !== 1'b1) begin nerr++; $display("FAIL sp_rd_ready: %b required 1", p0.req_ready); end
        tick();
        nvec++; if ({banksel, rd, wr} !== 3'b110 || address !== 9'h007 || wd !== d) begin nerr++; $display("FAIL sp_rd_pins: bsel/rd/wr=%b addr=%h wd=%h required 110/007/%h", {banksel, rd, wr}, address, wd, d); end
        nvec++; if (p0.rsp_valid !== 1'b0) begin nerr++; $display("FAIL sp_rsp_early: %b required 0", p0.rsp_valid); end
        set_req(0, 1'b0, 1'b0, 9'h000, 48'h0);
        tick();
        nvec++; if (p0.rsp_valid !== 1'b1 || p0.rsp_data !== d || p1.rsp_valid !== 1'b0) begin nerr++; $display("FAIL sp_rsp: v0=%b data=%h v1=%b required 1/%h/0", p0.rsp_valid, p0.rsp_data, p1.rsp_valid, d); end
        tick();
        nvec++; if ({p0.rsp_valid, p1.rsp_valid} !== 2'b00) begin nerr++; $display("FAIL sp_rsp_pulse: %b required 00", {p0.rsp_valid, p1.rsp_valid}); end
    endtask

    task automatic test_contention;
        logic [DW-1:0] d10, d20, exp_d;
        d10 = 48'hA5A5_0000_0010;
        d20 = 48'h5A5A_0000_0020;
        set_req(0, 1'b1, 1'b1, 9'h010, d10);
        tick();
        set_req(0, 1'b0, 1'b0, 9'h000, 48'h0);
        set_req(1, 1'b1, 1'b1, 9'h020, d20);
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                exp_d = ((c % 2) == 0) ? d10 : d20;
                nvec++;
                if (p0.rsp_valid !== ((c % 2) == 0) || p1.rsp_valid !== ((c % 2) == 1) || p0.rsp_data !== exp_d) begin
                    nerr++;
                    $display("FAIL cont_rsp[%0d]: v0=%b v1=%b data=%h required %b/%b/%h", c, p0.rsp_valid, p1.rsp_valid, p0.rsp_data, ((c % 2) == 0), ((c % 2) == 1), exp_d);
                end
            end else begin
                nvec++;
                if ({p0.rsp_valid, p1.rsp_valid} !== 2'b00) begin nerr++; $display("FAIL cont_rsp[%0d]: %b required 00", c, {p0.rsp_valid, p1.rsp_valid}); end
            end
            if (c < 4) begin
                set_req(0, 1'b1, 1'b0, 9'h010, 48'h0);
                set_req(1, 1'b1, 1'b0, 9'h020, 48'h0);
                #1;
                nvec++;
                if (p0.req_ready !== ((c % 2) == 0) || p1.req_ready !== ((c % 2) == 1)) begin
                    nerr++;
                    $display("FAIL cont_grant[%0d]: ready=%b%b required %b%b", c, p0.req_ready, p1.req_ready, ((c % 2) == 0), ((c % 2) == 1));
                end
            end else begin
                set_req(0, 1'b0, 1'b0, 9'h000, 48'h0);
                set_req(1, 1'b0, 1'b0, 9'h000, 48'h0);
            end
            tick();
        end
    endtask

    task automatic test_raw;
        logic [DW-1:0] d;
        d = 48'hFFFF00000001;
        set_req(1, 1'b1, 1'b1, 9'h1FF, d);
        #1;
        nvec++; if (p1.req_ready !== 1'b1) begin nerr++; $display("FAIL raw_wr_ready: %b required 1", p1.req_ready); end
        tick();
        set_req(1, 1'b0, 1'b0, 9'h000, 48'h0);
        set_req(0, 1'b1, 1'b0, 9'h1FF, 48'h0);
        #1;
        nvec++; if (p0.req_ready !== 1'b1) begin nerr++; $display("FAIL raw_rd_ready: %b required 1", p0.req_ready); end
        tick();
        set_req(0, 1'b0, 1'b0, 9'h000, 48'h0);
        tick();
        nvec++; if (p0.rsp_valid !== 1'b1 || p0.rsp_data !== d || p1.rsp_valid !== 1'b0) begin nerr++; $display("FAIL raw_rsp: v0=%b data=%h v1=%b required 1/%h/0", p0.rsp_valid, p0.rsp_data, p1.rsp_valid, d); end
        tick();
    endtask

    task automatic test_reset_midop;
        set_req(0, 1'b1, 1'b0, 9'h007, 48'h0);
        tick();
        set_req(0, 1'b0, 1'b0, 9'h000, 48'h0);
        nvec++; if (rd !== 1'b1) begin nerr++; $display("FAIL midrst_issue: read=%b required 1", rd); end
        #1 rst = 1'b1;
        #1;
        nvec++; if ({banksel, rd, wr} !== 3'b000) begin nerr++; $display("FAIL midrst_async: bsel/rd/wr=%b required 000", {banksel, rd, wr}); end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++;
            if ({p0.rsp_valid, p1.rsp_valid} !== 2'b00) begin nerr++; $display("FAIL midrst_no_rsp[%0d]: %b required 00", i, {p0.rsp_valid, p1.rsp_valid}); end
        end
        wait_init();
        set_req(0, 1'b1, 1'b0, 9'h007, 48'h0);
        set_req(1, 1'b1, 1'b0, 9'h007, 48'h0);
        #1;
        nvec++; if ({p0.req_ready, p1.req_ready} !== 2'b10) begin nerr++; $display("FAIL midrst_prio: ready=%b required 10", {p0.req_ready, p1.req_ready}); end
        set_req(0, 1'b0, 1'b0, 9'h000, 48'h0);
        set_req(1, 1'b0, 1'b0, 9'h000, 48'h0);
        tick();
    endtask

    initial begin
        set_req(0, 1'b0, 1'b0, 9'h000, 48'h0);
        set_req(1, 1'b0, 1'b0, 9'h000, 48'h0);
        test_reset();
        test_idle();
        test_single_port();
        test_contention();
        test_raw();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/srambank_arb2_ctrl.md
Name: srambank_arb2_ctrl

Overview:
- Controller that shares one 512x48 synchronous SRAM bank between two requesters (port 0, port 1).
- Arbitrates round-robin, one access per cycle, and drives the bank's address/data/select/read/write strobes from a registered command stage.
- Routes the bank's registered read data back to the requester that issued the read.
- After reset, optionally zero-fills the bank before accepting traffic.

Parameters:
- AW, 9, bank address width (depth 2**AW)
- DW, 48, data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_write  in  1  1=write, 0=read
- req0_addr  in  AW  port 0 address
- req0_wdata  in  DW  port 0 write data
- rsp0_valid  out  1  port 0 read data valid (one-cycle pulse)
- rsp0_data  out  DW  port 0 read data
- req1_*/rsp1_*  same as port 0, for port 1
- ADDRESS  out  AW  to bank
- wd  out  DW  to bank
- banksel  out  1  to bank
- read  out  1  to bank
- write  out  1  to bank
- dataout  in  DW  from bank (registered, updated only on read)
- init_done  out  1  high once the controller is accepting requests

Behaviour:
- Reset values:
  - ADDRESS=0, wd=0, banksel=0, read=0, write=0, rsp*_valid=0, init_done=0.
  - Round-robin pointer points at port 0 (port 0 wins the first tie).
  - In-flight read tracking is cleared; any read issued before reset never produces a response.
  - Reset may assert in any cycle.
- FSM states: INIT (zero-fill, only with the optional feature), RUN.
  - Leaving reset goes to INIT if the feature is enabled, else to RUN.
  - INIT goes to RUN after the last address is written.
  - init_done=1 exactly while in RUN.
- Ready rule:
  - reqN_ready is combinational and only asserted in RUN.
  - Fire on cycle T = reqN_valid & reqN_ready at the edge ending T.
  - Requesters hold request fields stable until fire.
- Arbitration, in RUN:
  - One valid request: grant it.
  - Both valid: grant the port not granted most recently.
  - The pointer updates only on a fire.
  - At most one ready per cycle; no fire costs no bubble (back-to-back grants allowed).
- Command stage: a fire on T registers onto the bank pins during T+1.
  - ADDRESS=addr, banksel=1.
  - Write request: write=1, read=0, wd=wdata.
  - Read request: write=0, read=1; wd is unchanged.
  - A cycle with no fire drives banksel=read=write=0 during the next cycle; ADDRESS and wd hold their last values.
- Read return:
  - The bank captures data at the end of T+1.
  - rspN_valid=1 during cycle T+2 for the originating port, so read latency from fire is 2 cycles.
  - rspN_data = dataout, passed through combinationally. rspN_data is don't-care when rspN_valid=0.
  - A two-entry shift of {valid, port} tracks in-flight reads.
  - Back-to-back reads from alternating ports return in order, one per cycle.
- Writes produce no response.
- Read-after-write to the same address fired on consecutive cycles returns the new data; the bank orders the write first.
- No read and write are ever issued in the same cycle, since one grant per cycle.

Optional Feature:
- SRAMBANK_ARB_INIT_CLEAR_EN defined:
  - After reset, the FSM enters INIT and holds an AW-bit counter starting at 0.
  - Each INIT cycle drives ADDRESS=counter, wd=0, banksel=1, write=1, read=0.
  - INIT lasts 2**AW cycles (512 by default), then goes to RUN; init_done rises the following cycle.
  - Requests arriving during INIT wait with ready=0.
  - Reset during INIT restarts the fill at address 0.
- Not defined: no INIT state; RUN is entered directly from reset and init_done=1 from the first cycle after reset deasserts.

Test Plan:
- Reset/init (feature on): release rst -> write=1 for 512 consecutive cycles with ADDRESS 0..511 and wd=0; init_done=1 afterwards. Port 0 read of address 0x1A5 -> rsp0_data=0.
- Single-port write/read: port 0 writes 0x123456789ABC to address 0x07, then reads 0x07 -> rsp0_valid exactly 2 cycles after the read fire, with rsp0_data=0x123456789ABC; rsp1_valid stays 0.
- Contention: both ports valid every cycle with reads of 0x10 and 0x20 -> grants alternate 0,1,0,1, starting with port 0; each port gets a response every other cycle with the correct data.
- Read-after-write: port 1 writes 0xFFFF00000001 to 0x1FF in cycle T, port 0 reads 0x1FF in T+1 -> rsp0_data=0xFFFF00000001.
- Reset mid-operation: assert rst one cycle after a read fire -> no rsp valid pulse; all bank strobes go to 0 immediately (asynchronously).
- Idle: no requests -> banksel=read=write=0 every cycle; ready follows the arbitration rule.
